// File: rtl/segment_addr_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : segment_addr_ctrl
// Purpose  : Pointer/handshake control for the buff and so circular queues
//            feeding the segment SRAM. Sticky error flags built only when
//            SEG_ADDR_CTRL_ERR_FLAG_EN is defined.
// Revision : 1.0
// ============================================================================

`ifndef NUM_BUFF_SO_WORDS_SEG
`define NUM_BUFF_SO_WORDS_SEG 4
`endif
`ifndef BITS_ADDR_SEG
`define BITS_ADDR_SEG 2
`endif

module segment_addr_ctrl #(
  parameter int NUM_BUFF_SO_WORDS_SEG = `NUM_BUFF_SO_WORDS_SEG,
  parameter int DEPTH_SO_Q            = 1,
  parameter int BITS_ADDR_SEG         = `BITS_ADDR_SEG,
  parameter int BITS_SO_Q             = 0,
  parameter int BITS_ADDR_SEG_SO      = BITS_ADDR_SEG + BITS_SO_Q
) (
  input  logic                        clk,
  input  logic                        rst_b,
  input  logic                        push,
  input  logic                        pop_buff,
  input  logic                        pop_so,
  output logic                        wr_en_adv,
  output logic                        rd_en_buff_adv,
  output logic                        rd_en_so_adv,
  output logic [BITS_ADDR_SEG-1:0]    adv_wr_addr_buff,
  output logic [BITS_ADDR_SEG-1:0]    adv_rd_addr_buff,
  output logic [BITS_ADDR_SEG_SO-1:0] adv_wr_addr_so,
  output logic [BITS_ADDR_SEG_SO-1:0] adv_rd_addr_so,
  output logic                        adv_rd_wr_addr_match_flag_buff,
  output logic                        adv_rd_wr_addr_match_flag_so,
  output logic                        rd_wr_addr_match_flag_buff,
  output logic                        rd_wr_addr_match_flag_so,
  output logic                        mandatory_bubble_buff,
  output logic                        mandatory_bubble_so,
  output logic                        dout_valid_buff,
  output logic                        dout_valid_so,
  output logic                        full_buff,
  output logic                        empty_buff,
  output logic                        full_so,
  output logic                        empty_so,
  output logic [BITS_ADDR_SEG:0]      cnt_buff,
  output logic [BITS_ADDR_SEG_SO:0]   cnt_so,
  output logic                        err_overflow,
  output logic                        err_underflow
);

  localparam int c_DEPTH_SO = NUM_BUFF_SO_WORDS_SEG * DEPTH_SO_Q;

  localparam logic [BITS_ADDR_SEG-1:0]    c_LAST_BUFF = BITS_ADDR_SEG'(NUM_BUFF_SO_WORDS_SEG - 1);
  localparam logic [BITS_ADDR_SEG_SO-1:0] c_LAST_SO   = BITS_ADDR_SEG_SO'(c_DEPTH_SO - 1);
  localparam logic [BITS_ADDR_SEG-1:0]    c_PTR1_BUFF = BITS_ADDR_SEG'(1);
  localparam logic [BITS_ADDR_SEG_SO-1:0] c_PTR1_SO   = BITS_ADDR_SEG_SO'(1);
  localparam logic [BITS_ADDR_SEG:0]      c_FULL_BUFF = (BITS_ADDR_SEG + 1)'(NUM_BUFF_SO_WORDS_SEG);
  localparam logic [BITS_ADDR_SEG_SO:0]   c_FULL_SO   = (BITS_ADDR_SEG_SO + 1)'(c_DEPTH_SO);
  localparam logic [BITS_ADDR_SEG:0]      c_CNT1_BUFF = (BITS_ADDR_SEG + 1)'(1);
  localparam logic [BITS_ADDR_SEG_SO:0]   c_CNT1_SO   = (BITS_ADDR_SEG_SO + 1)'(1);

  logic [BITS_ADDR_SEG-1:0]    r_wr_ptr_buff, r_rd_ptr_buff;
  logic [BITS_ADDR_SEG_SO-1:0] r_wr_ptr_so, r_rd_ptr_so;
  logic [BITS_ADDR_SEG:0]      r_cnt_buff;
  logic [BITS_ADDR_SEG_SO:0]   r_cnt_so;
  logic                        r_match_buff, r_match_so;
  logic                        r_bubble_buff, r_bubble_so;
  logic                        r_valid_buff, r_valid_so;

  logic [BITS_ADDR_SEG-1:0]    w_wr_ptr_buff_nxt, w_rd_ptr_buff_nxt;
  logic [BITS_ADDR_SEG_SO-1:0] w_wr_ptr_so_nxt, w_rd_ptr_so_nxt;
  logic [BITS_ADDR_SEG:0]      w_cnt_buff_nxt;
  logic [BITS_ADDR_SEG_SO:0]   w_cnt_so_nxt;

  logic w_full_buff, w_empty_buff, w_full_so, w_empty_so;
  logic w_wr_en, w_rd_en_buff, w_rd_en_so;
  logic w_match_buff, w_match_so;

  // Status reflects the state before this cycle's requests (full is pre-pop)
  assign w_full_buff  = (r_cnt_buff == c_FULL_BUFF);
  assign w_empty_buff = (r_cnt_buff == '0);
  assign w_full_so    = (r_cnt_so == c_FULL_SO);
  assign w_empty_so   = (r_cnt_so == '0);

  assign w_wr_en      = push & ~w_full_buff & ~w_full_so;
  assign w_rd_en_buff = pop_buff & (~w_empty_buff | w_wr_en);
  assign w_rd_en_so   = pop_so & (~w_empty_so | w_wr_en);

  // Equal pointers with both ops accepted only happens on an empty queue
  assign w_match_buff = w_rd_en_buff & w_wr_en & (r_rd_ptr_buff == r_wr_ptr_buff);
  assign w_match_so   = w_rd_en_so & w_wr_en & (r_rd_ptr_so == r_wr_ptr_so);

  always_comb begin
    w_wr_ptr_buff_nxt = r_wr_ptr_buff;
    w_rd_ptr_buff_nxt = r_rd_ptr_buff;
    w_wr_ptr_so_nxt   = r_wr_ptr_so;
    w_rd_ptr_so_nxt   = r_rd_ptr_so;
    w_cnt_buff_nxt    = r_cnt_buff;
    w_cnt_so_nxt      = r_cnt_so;

    if (w_wr_en) begin
      w_wr_ptr_buff_nxt = (r_wr_ptr_buff == c_LAST_BUFF) ? '0 : r_wr_ptr_buff + c_PTR1_BUFF;
      w_wr_ptr_so_nxt   = (r_wr_ptr_so == c_LAST_SO) ? '0 : r_wr_ptr_so + c_PTR1_SO;
    end
    if (w_rd_en_buff) begin
      w_rd_ptr_buff_nxt = (r_rd_ptr_buff == c_LAST_BUFF) ? '0 : r_rd_ptr_buff + c_PTR1_BUFF;
    end
    if (w_rd_en_so) begin
      w_rd_ptr_so_nxt = (r_rd_ptr_so == c_LAST_SO) ? '0 : r_rd_ptr_so + c_PTR1_SO;
    end

    case ({w_wr_en, w_rd_en_buff})
      2'b10:   w_cnt_buff_nxt = r_cnt_buff + c_CNT1_BUFF;
      2'b01:   w_cnt_buff_nxt = r_cnt_buff - c_CNT1_BUFF;
      default: w_cnt_buff_nxt = r_cnt_buff;
    endcase

    case ({w_wr_en, w_rd_en_so})
      2'b10:   w_cnt_so_nxt = r_cnt_so + c_CNT1_SO;
      2'b01:   w_cnt_so_nxt = r_cnt_so - c_CNT1_SO;
      default: w_cnt_so_nxt = r_cnt_so;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_b) begin
      r_wr_ptr_buff <= '0;
      r_rd_ptr_buff <= '0;
      r_wr_ptr_so   <= '0;
      r_rd_ptr_so   <= '0;
      r_cnt_buff    <= '0;
      r_cnt_so      <= '0;
      r_match_buff  <= 1'b0;
      r_match_so    <= 1'b0;
      r_bubble_buff <= 1'b0;
      r_bubble_so   <= 1'b0;
      r_valid_buff  <= 1'b0;
      r_valid_so    <= 1'b0;
    end else begin
      r_wr_ptr_buff <= w_wr_ptr_buff_nxt;
      r_rd_ptr_buff <= w_rd_ptr_buff_nxt;
      r_wr_ptr_so   <= w_wr_ptr_so_nxt;
      r_rd_ptr_so   <= w_rd_ptr_so_nxt;
      r_cnt_buff    <= w_cnt_buff_nxt;
      r_cnt_so      <= w_cnt_so_nxt;
      r_match_buff  <= w_match_buff;
      r_match_so    <= w_match_so;
      // Read at t -> output-register enable at t+1 -> data valid at t+2
      r_bubble_buff <= w_rd_en_buff;
      r_bubble_so   <= w_rd_en_so;
      r_valid_buff  <= r_bubble_buff;
      r_valid_so    <= r_bubble_so;
    end
  end

  assign wr_en_adv                      = w_wr_en;
  assign rd_en_buff_adv                 = w_rd_en_buff;
  assign rd_en_so_adv                   = w_rd_en_so;
  assign adv_wr_addr_buff               = r_wr_ptr_buff;
  assign adv_rd_addr_buff               = r_rd_ptr_buff;
  assign adv_wr_addr_so                 = r_wr_ptr_so;
  assign adv_rd_addr_so                 = r_rd_ptr_so;
  assign adv_rd_wr_addr_match_flag_buff = w_match_buff;
  assign adv_rd_wr_addr_match_flag_so   = w_match_so;
  assign rd_wr_addr_match_flag_buff     = r_match_buff;
  assign rd_wr_addr_match_flag_so       = r_match_so;
  assign mandatory_bubble_buff          = r_bubble_buff;
  assign mandatory_bubble_so            = r_bubble_so;
  assign dout_valid_buff                = r_valid_buff;
  assign dout_valid_so                  = r_valid_so;
  assign full_buff                      = w_full_buff;
  assign empty_buff                     = w_empty_buff;
  assign full_so                        = w_full_so;
  assign empty_so                       = w_empty_so;
  assign cnt_buff                       = r_cnt_buff;
  assign cnt_so                         = r_cnt_so;

`ifdef SEG_ADDR_CTRL_ERR_FLAG_EN
  logic r_err_overflow, r_err_underflow;
  logic w_ovf_evt, w_unf_evt;

  // An underflowing pop is one that is neither served from storage nor write-through
  assign w_ovf_evt = push & (w_full_buff | w_full_so);
  assign w_unf_evt = (pop_buff & w_empty_buff & ~w_wr_en) |
                     (pop_so & w_empty_so & ~w_wr_en);

  always_ff @(posedge clk) begin
    if (!rst_b) begin
      r_err_overflow  <= 1'b0;
      r_err_underflow <= 1'b0;
    end else begin
      if (w_ovf_evt) r_err_overflow <= 1'b1;
      if (w_unf_evt) r_err_underflow <= 1'b1;
    end
  end

  assign err_overflow  = r_err_overflow;
  assign err_underflow = r_err_underflow;
`else
  assign err_overflow  = 1'b0;
  assign err_underflow = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_segment_addr_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_segment_addr_ctrl
// Purpose  : Randomized scoreboard bench for segment_addr_ctrl (N=4, so x2).
// Revision : 1.0
// ============================================================================

module tb_segment_addr_ctrl;

  localparam int NB = 4;
  localparam int DQ = 2;
  localparam int NS = NB * DQ;
  localparam int BA = 2;
  localparam int BQ = 1;
  localparam int BS = BA + BQ;

  logic          clk = 1'b0;
  logic          rst_b = 1'b1;
  logic          push = 1'b0;
  logic          pop_buff = 1'b0;
  logic          pop_so = 1'b0;
  logic          wr_en_adv, rd_en_buff_adv, rd_en_so_adv;
  logic [BA-1:0] adv_wr_addr_buff, adv_rd_addr_buff;
  logic [BS-1:0] adv_wr_addr_so, adv_rd_addr_so;
  logic          adv_rd_wr_addr_match_flag_buff, adv_rd_wr_addr_match_flag_so;
  logic          rd_wr_addr_match_flag_buff, rd_wr_addr_match_flag_so;
  logic          mandatory_bubble_buff, mandatory_bubble_so;
  logic          dout_valid_buff, dout_valid_so;
  logic          full_buff, empty_buff, full_so, empty_so;
  logic [BA:0]   cnt_buff;
  logic [BS:0]   cnt_so;
  logic          err_overflow, err_underflow;

  segment_addr_ctrl #(
    .NUM_BUFF_SO_WORDS_SEG(NB),
    .DEPTH_SO_Q           (DQ),
    .BITS_ADDR_SEG        (BA),
    .BITS_SO_Q            (BQ),
    .BITS_ADDR_SEG_SO     (BS)
  ) dut (
    .clk                           (clk),
    .rst_b                         (rst_b),
    .push                          (push),
    .pop_buff                      (pop_buff),
    .pop_so                        (pop_so),
    .wr_en_adv                     (wr_en_adv),
    .rd_en_buff_adv                (rd_en_buff_adv),
    .rd_en_so_adv                  (rd_en_so_adv),
    .adv_wr_addr_buff              (adv_wr_addr_buff),
    .adv_rd_addr_buff              (adv_rd_addr_buff),
    .adv_wr_addr_so                (adv_wr_addr_so),
    .adv_rd_addr_so                (adv_rd_addr_so),
    .adv_rd_wr_addr_match_flag_buff(adv_rd_wr_addr_match_flag_buff),
    .adv_rd_wr_addr_match_flag_so  (adv_rd_wr_addr_match_flag_so),
    .rd_wr_addr_match_flag_buff    (rd_wr_addr_match_flag_buff),
    .rd_wr_addr_match_flag_so      (rd_wr_addr_match_flag_so),
    .mandatory_bubble_buff         (mandatory_bubble_buff),
    .mandatory_bubble_so           (mandatory_bubble_so),
    .dout_valid_buff               (dout_valid_buff),
    .dout_valid_so                 (dout_valid_so),
    .full_buff                     (full_buff),
    .empty_buff                    (empty_buff),
    .full_so                       (full_so),
    .empty_so                      (empty_so),
    .cnt_buff                      (cnt_buff),
    .cnt_so                        (cnt_so),
    .err_overflow                  (err_overflow),
    .err_underflow                 (err_underflow)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_bad = 0;
  int cyc   = 0;
  bit armed = 1'b0;

  // Reference model: each queue holds the slot addresses of stored words
  int mq_buff[$];
  int mq_so[$];
  int wr_total = 0;
  bit m_ovf = 1'b0;
  bit m_unf = 1'b0;

  typedef struct {
    int due;
    bit match;
  } pop_t;
  pop_t sb_buff[$];
  pop_t sb_so[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic model_reset();
    mq_buff.delete();
    mq_so.delete();
    sb_buff.delete();
    sb_so.delete();
    wr_total = 0;
    m_ovf = 1'b0;
    m_unf = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_b = 1'b0; push = 1'b0; pop_buff = 1'b0; pop_so = 1'b0;
    @(posedge clk);
    cyc++;
    model_reset();
    armed = 1'b1;
    #2;
    rst_b = 1'b1;
    chk("rst cnt_buff", cnt_buff, 0);
    chk("rst cnt_so", cnt_so, 0);
    chk("rst empty_buff", empty_buff, 1);
    chk("rst empty_so", empty_so, 1);
    chk("rst full_buff", full_buff, 0);
    chk("rst wr_addr_so", adv_wr_addr_so, 0);
    chk("rst rd_addr_buff", adv_rd_addr_buff, 0);
    chk("rst dout_valid_buff", dout_valid_buff, 0);
    chk("rst dout_valid_so", dout_valid_so, 0);
    chk("rst err_overflow", err_overflow, 0);
  endtask

  task automatic step(input bit p, input bit pb, input bit ps);
    bit e_wr, e_rb, e_rs, e_mb, e_ms, eb0, es0;
    int wa_b, wa_s, ra_b, ra_s, dummy;
    pop_t ent;
    @(negedge clk);
    push = p; pop_buff = pb; pop_so = ps;
    #1;
    eb0  = (mq_buff.size() == 0);
    es0  = (mq_so.size() == 0);
    e_wr = p && (mq_buff.size() < NB) && (mq_so.size() < NS);
    e_rb = pb && (!eb0 || e_wr);
    e_rs = ps && (!es0 || e_wr);
    wa_b = wr_total % NB;
    wa_s = wr_total % NS;
    ra_b = eb0 ? wa_b : mq_buff[0];
    ra_s = es0 ? wa_s : mq_so[0];
    e_mb = e_rb && e_wr && eb0;
    e_ms = e_rs && e_wr && es0;

    chk("wr_en_adv", wr_en_adv, e_wr);
    chk("rd_en_buff_adv", rd_en_buff_adv, e_rb);
    chk("rd_en_so_adv", rd_en_so_adv, e_rs);
    chk("adv_wr_addr_buff", adv_wr_addr_buff, wa_b);
    chk("adv_wr_addr_so", adv_wr_addr_so, wa_s);
    chk("adv_rd_addr_buff", adv_rd_addr_buff, ra_b);
    chk("adv_rd_addr_so", adv_rd_addr_so, ra_s);
    chk("adv_match_buff", adv_rd_wr_addr_match_flag_buff, e_mb);
    chk("adv_match_so", adv_rd_wr_addr_match_flag_so, e_ms);
    chk("cnt_buff", cnt_buff, mq_buff.size());
    chk("cnt_so", cnt_so, mq_so.size());
    chk("full_buff", full_buff, mq_buff.size() == NB);
    chk("full_so", full_so, mq_so.size() == NS);
    chk("empty_buff", empty_buff, eb0);
    chk("empty_so", empty_so, es0);
    chk("err_overflow", err_overflow, m_ovf);
    chk("err_underflow", err_underflow, m_unf);

    @(posedge clk);
    cyc++;
`ifdef SEG_ADDR_CTRL_ERR_FLAG_EN
    if (p && (mq_buff.size() == NB || mq_so.size() == NS)) m_ovf = 1'b1;
    if ((pb && eb0 && !e_wr) || (ps && es0 && !e_wr)) m_unf = 1'b1;
`endif
    if (e_rb) begin
      ent.due = cyc + 1; ent.match = e_mb;
      sb_buff.push_back(ent);
      if (!eb0) dummy = mq_buff.pop_front();
    end
    if (e_rs) begin
      ent.due = cyc + 1; ent.match = e_ms;
      sb_so.push_back(ent);
      if (!es0) dummy = mq_so.pop_front();
    end
    if (e_wr) begin
      if (!(e_rb && eb0)) mq_buff.push_back(wa_b);
      if (!(e_rs && es0)) mq_so.push_back(wa_s);
      wr_total++;
    end
  endtask

  // Monitor: registered flags and dout_valid against the scoreboard
  always @(negedge clk) begin
    bit   xb, xm;
    pop_t tmp;
    if (armed) begin
      xb = 1'b0; xm = 1'b0;
      foreach (sb_buff[i]) if (sb_buff[i].due == cyc + 1) begin xb = 1'b1; xm = sb_buff[i].match; end
      chk("mandatory_bubble_buff", mandatory_bubble_buff, xb);
      chk("rd_wr_match_buff", rd_wr_addr_match_flag_buff, xm);
      if (sb_buff.size() > 0 && sb_buff[0].due == cyc) begin
        chk("dout_valid_buff", dout_valid_buff, 1);
        tmp = sb_buff.pop_front();
      end else begin
        chk("dout_valid_buff", dout_valid_buff, 0);
      end

      xb = 1'b0; xm = 1'b0;
      foreach (sb_so[i]) if (sb_so[i].due == cyc + 1) begin xb = 1'b1; xm = sb_so[i].match; end
      chk("mandatory_bubble_so", mandatory_bubble_so, xb);
      chk("rd_wr_match_so", rd_wr_addr_match_flag_so, xm);
      if (sb_so.size() > 0 && sb_so[0].due == cyc) begin
        chk("dout_valid_so", dout_valid_so, 1);
        tmp = sb_so.pop_front();
      end else begin
        chk("dout_valid_so", dout_valid_so, 0);
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation exceeded time bound");
    $fatal(1, "timeout");
  end

  initial begin
    int pp, pb, ps;
    do_reset();

    // Fill buff, then one rejected push
    for (int i = 0; i < 4; i++) step(1, 0, 0);
    #1;
    chk("fill full_buff", full_buff, 1);
    chk("fill cnt_buff", cnt_buff, 4);
    chk("fill cnt_so", cnt_so, 4);
    chk("fill full_so", full_so, 0);
    step(1, 0, 0);
    #1;
    chk("ovf cnt_buff", cnt_buff, 4);
`ifdef SEG_ADDR_CTRL_ERR_FLAG_EN
    chk("ovf err_overflow", err_overflow, 1);
`else
    chk("ovf err_overflow", err_overflow, 0);
`endif

    // Drain both, then a write-through on empty buff
    for (int i = 0; i < 4; i++) step(0, 1, 0);
    for (int i = 0; i < 4; i++) step(0, 0, 1);
    step(1, 1, 0);
    step(0, 0, 1);

    // Three pushes, then back-to-back pops
    for (int i = 0; i < 3; i++) step(1, 0, 0);
    for (int i = 0; i < 3; i++) step(0, 1, 0);
    for (int i = 0; i < 3; i++) step(0, 0, 1);
    for (int i = 0; i < 3; i++) step(0, 0, 0);

    // Steady push+pop so with non-empty queues: so addresses wrap
    step(1, 0, 0);
    step(1, 0, 0);
    for (int i = 0; i < 10; i++) step(1, 1, 1);

    // Reset mid-burst with cnt_buff = 2
    step(1, 1, 1);
    do_reset();

    // Randomized phases with varying request density
    for (int ph = 0; ph < 6; ph++) begin
      pp = $urandom_range(20, 90);
      pb = $urandom_range(10, 90);
      ps = $urandom_range(10, 90);
      for (int i = 0; i < 100; i++) begin
        if ($urandom_range(0, 99) < 2) do_reset();
        else step($urandom_range(0, 99) < pp, $urandom_range(0, 99) < pb,
                  $urandom_range(0, 99) < ps);
      end
    end

    for (int i = 0; i < 4; i++) step(0, 0, 0);
    chk("sb_buff drained", sb_buff.size(), 0);
    chk("sb_so drained", sb_so.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
